axis_fifo_ctrl: RTL and testbench
=================================

// Module: axis_fifo_ctrl
// PURPOSE
//   Control stage of the AXI-Stream FIFO. Accepts AXIS beats and writes them as aligned words into the
//   single-clock simple dual-port RAM (SdpRam1, OREG=1), then reads them back out in order.
//   Sustains 1 beat/clk on both sides. tlast is kept in a DEPTH-bit side array in this block.
//   Sits between the upstream AXIS source, the RAM and the downstream AXIS sink.
// PARAMETERS
//   BLEN   8                      bits per RAM byte lane
//   WLEN   4                      bytes per beat; power of 2
//   DLEN   BLEN*WLEN              tdata width
//   DEPTH  256                    RAM words; power of 2, >=2
//   ALEN   $clog2(DEPTH*WLEN)     RAM byte-address width (matches RAM MLEN=DEPTH*WLEN)
//   CLEN   $clog2(DEPTH+3)        o_count width
// PORTS
//   clk            in   1     clock
//   rstn           in   1     synchronous active-low reset
//   s_axis_tvalid  in   1     upstream beat valid
//   s_axis_tready  out  1     = !full; registered-only, no path from m_axis_tready
//   s_axis_tdata   in   DLEN  upstream data
//   s_axis_tlast   in   1     upstream end of packet
//   m_axis_tvalid  out  1     downstream beat valid
//   m_axis_tready  in   1     downstream accept
//   m_axis_tdata   out  DLEN  downstream data
//   m_axis_tlast   out  1     downstream end of packet
//   o_wen          out  1     RAM write enable (= s handshake)
//   o_waddr        out  ALEN  {wptr[idx], log2(WLEN) zeros}; always word-aligned
//   o_wdata        out  DLEN  = s_axis_tdata
//   o_ren          out  1     RAM read issue
//   o_raddr        out  ALEN  {rptr[idx], zeros}
//   i_rdata        in   DLEN  RAM read data, valid 1 clk after o_ren
//   o_count        out  CLEN  beats held: RAM words + in-flight read + output buffer
//   o_full, o_empty out 1     RAM-word full (mem_cnt==DEPTH) / o_count==0
// BEHAVIOUR
//   - Reset (rstn=0 at edge): wptr=rptr=0, mem_cnt=0, inflight=0, out buffer empty.
//     Outputs: s_axis_tready=0 during reset, 1 in the first cycle after. m_axis_tvalid=0,
//     o_wen=o_ren=0, o_count=0, o_empty=1, o_full=0. Reset mid-packet discards all content.
//   - Pointers are $clog2(DEPTH)+1 bits with a wrap bit. Full = idx equal and wrap bits differ.
//     idx wraps DEPTH-1 -> 0.
//   - Write: on s_axis_tvalid&&s_axis_tready, o_wen=1 that cycle, the tlast flag is stored at
//     wptr idx, and wptr++ at the edge.
//   - Read issue: o_ren=1 when mem_cnt>0 && credit>0. credit = 2 - buf_occ - inflight, where
//     buf_occ/inflight are evaluated after this cycle's pop. rptr++ and inflight=1 at the edge.
//   - Return: the cycle after issue, i_rdata plus the flag at the issued idx are pushed into the
//     2-entry output buffer.
//   - Latency: a beat accepted at edge E0 into an empty FIFO gives m_axis_tvalid=1 in the cycle
//     after edge E2. There is no bypass path.
//   - Out buffer: FIFO order, m_axis_* driven from the head. A pop on m_axis_tvalid&&m_axis_tready
//     frees a credit in the same cycle. m_axis_tdata/tlast stay stable while tvalid&&!tready.
//   - mem_cnt += push - issue. o_count += s_hs - m_hs; max DEPTH+2.
//   - Simultaneous push and read at the same idx cannot occur: a read is only issued on committed
//     words.
//   - When full: s_axis_tready=0 even if a read issues this cycle; it re-asserts the next cycle.
//   - When empty: o_ren=0; m_axis_tready is ignored while tvalid=0.
// STRUCTURE
//   - Package axis_fifo_pkg: ptr_t/idx_t widths derived from DEPTH, and a function
//     word2addr(idx) -> ALEN byte address.
//   - Sub-module axis_fifo_obuf: 2-entry buffer {tdata,tlast} with push/pop/occ.
//   - Top instantiates axis_fifo_obuf only. The RAM is instantiated by the FIFO wrapper.
// TESTING (DEPTH=4, WLEN=4; bench models SdpRam1 with OREG=1)
//   - Reset: rstn=0 for 3 clk -> all outputs at reset values. Cycle after release:
//     s_axis_tready=1, o_count=0.
//   - Single beat 0xDEADBEEF, tlast=1 at E0 -> o_waddr=0x0 with o_wen.
//     o_ren/o_raddr=0x0 the next cycle. m_axis beat 0xDEADBEEF, tlast=1 after E2.
//   - Fill with m_axis_tready=0, writes 1..7:
//     - 6 accepted (4 RAM + 2 buffer), then o_full=1, s_axis_tready=0, o_count=6.
//     - Waddrs 0x0,0x4,0x8,0xC,0x0,0x4; the 7th beat is held.
//   - Streaming with both sides always ready, 100 beats -> 1 beat/clk after initial latency,
//     data in order, no drops/duplicates, pointers wrap correctly.
//   - Random tvalid/tready back-pressure, 1000 beats with tlast every 5th ->
//     - output equals input, including tlast;
//     - m_axis_tdata stable while stalled.
//   - Reset asserted with o_count=5 mid-packet -> after release: o_count=0, m_axis_tvalid=0,
//     and the next beat written goes to o_waddr=0x0.

Source files
------------

// File: rtl/axis_fifo_pkg.sv
// -----------------------------------------------------------------------------
// axis_fifo_pkg
// Shared helpers for the AXI-Stream FIFO control stage.
//   ptr_w()     : width of a read/write pointer for a given RAM depth. The
//                 pointer is one bit wider than the word index; that extra
//                 wrap bit tells full from empty when the indices match.
//   word2addr() : converts a RAM word index to the RAM byte address. The
//                 result is always word-aligned.
// Each FIFO instance builds its ptr_t/idx_t types from its own DEPTH by
// calling ptr_w(). This lets a single package serve every FIFO depth.
// -----------------------------------------------------------------------------
package axis_fifo_pkg;

    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic logic [31:0] word2addr(input logic [31:0] idx,
                                              input int unsigned  wlen);
        return idx << $clog2(wlen);
    endfunction

endpackage

// File: rtl/axis_fifo_obuf.sv
// -----------------------------------------------------------------------------
// axis_fifo_obuf
// A 2-entry first-in first-out buffer that holds {tdata, tlast} beats
// returned by the RAM. The downstream AXIS port is driven from the head entry.
//   clk, rstn       clock, synchronous active-low reset
//   push            write push_data/push_last into the tail entry
//   push_data/last  beat returned by the RAM
//   pop             remove the head entry (downstream handshake)
//   head_data/last  head entry. Only meaningful while occ != 0.
//   occ             number of entries held (0..2)
// Reset clears only the control state. The data entries are don't-care while
// they are empty.
// -----------------------------------------------------------------------------
module axis_fifo_obuf #(
    parameter int DLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            push,
    input  logic [DLEN-1:0] push_data,
    input  logic            push_last,
    input  logic            pop,
    output logic [DLEN-1:0] head_data,
    output logic            head_last,
    output logic [1:0]      occ
);

    logic [DLEN-1:0] data_q [2];
    logic [1:0]      last_q;
    logic            wsel;
    logic            rsel;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wsel <= 1'b0;
            rsel <= 1'b0;
            occ  <= 2'd0;
        end else begin
            if (push) wsel <= ~wsel;
            if (pop)  rsel <= ~rsel;
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wsel] <= push_data;
            last_q[wsel] <= push_last;
        end
    end

    assign head_data = data_q[rsel];
    assign head_last = last_q[rsel];

endmodule

// File: rtl/axis_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// axis_fifo_ctrl
// Control stage of the AXI-Stream FIFO. It writes accepted beats into an
// external simple dual-port RAM. The RAM read data arrives one clock after
// o_ren. The block reads the beats back in order through a 2-entry output
// buffer, and it sustains one beat per clock in each direction.
// tlast is not stored in the RAM. It is kept in a DEPTH-bit side array here.
//   clk, rstn                     clock, synchronous active-low reset
//   s_axis_tvalid/tready/tdata/tlast   upstream AXIS. tready is a registered !full.
//   m_axis_tvalid/tready/tdata/tlast   downstream AXIS
//   o_wen, o_waddr, o_wdata       RAM write port (byte address, word-aligned)
//   o_ren, o_raddr, i_rdata       RAM read port
//   o_count                       beats held (RAM + in-flight read + buffer)
//   o_full, o_empty               RAM words full / nothing held
// -----------------------------------------------------------------------------
module axis_fifo_ctrl
    import axis_fifo_pkg::*;
#(
    parameter int BLEN  = 8,
    parameter int WLEN  = 4,
    parameter int DLEN  = BLEN * WLEN,
    parameter int DEPTH = 256,
    parameter int ALEN  = $clog2(DEPTH * WLEN),
    parameter int CLEN  = $clog2(DEPTH + 3)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            s_axis_tvalid,
    output logic            s_axis_tready,
    input  logic [DLEN-1:0] s_axis_tdata,
    input  logic            s_axis_tlast,
    output logic            m_axis_tvalid,
    input  logic            m_axis_tready,
    output logic [DLEN-1:0] m_axis_tdata,
    output logic            m_axis_tlast,
    output logic            o_wen,
    output logic [ALEN-1:0] o_waddr,
    output logic [DLEN-1:0] o_wdata,
    output logic            o_ren,
    output logic [ALEN-1:0] o_raddr,
    input  logic [DLEN-1:0] i_rdata,
    output logic [CLEN-1:0] o_count,
    output logic            o_full,
    output logic            o_empty
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = ptr_w(DEPTH);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [IW-1:0] idx_t;

    ptr_t            wptr;
    ptr_t            rptr;
    ptr_t            wptr_nxt;
    ptr_t            rptr_nxt;
    ptr_t            mem_cnt;
    idx_t            widx;
    idx_t            ridx;
    logic            s_hs;
    logic            m_hs;
    logic            full;
    logic            full_nxt;
    logic            tready_q;
    logic [1:0]      occ;
    logic [1:0]      occ_after;
    logic [CLEN-1:0] count_q;
    logic [DEPTH-1:0] last_mem;
    logic            vld_p0;
    logic            vld_p1;
    logic            last_p1;

    assign widx = wptr[IW-1:0];
    assign ridx = rptr[IW-1:0];

    assign s_hs = s_axis_tvalid && tready_q;
    assign m_hs = m_axis_tvalid && m_axis_tready;

    // mem_cnt counts committed words that have not been read yet. The
    // modular pointer difference gives 0..DEPTH.
    assign mem_cnt = wptr - rptr;
    assign full    = (widx == ridx) && (wptr[IW] != rptr[IW]);

    // ---- stage p0: read issue ---------------------------------------------
    // A read is issued only when its data has a guaranteed slot in the output
    // buffer when it returns. The slot count uses the buffer occupancy after
    // this cycle's pop, plus the read already in flight.
    assign occ_after = occ + {1'b0, vld_p1} - {1'b0, m_hs};
    assign vld_p0    = (mem_cnt != '0) && (occ_after < 2'd2);

    assign wptr_nxt = wptr + PW'(s_hs);
    assign rptr_nxt = rptr + PW'(vld_p0);
    // tready is registered. It is computed from the pointers as they will be
    // after this edge, so that no combinational path runs from m_axis_tready
    // to s_axis_tready.
    assign full_nxt = (wptr_nxt[IW-1:0] == rptr_nxt[IW-1:0]) &&
                      (wptr_nxt[IW] != rptr_nxt[IW]);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr     <= '0;
            rptr     <= '0;
            vld_p1   <= 1'b0;
            tready_q <= 1'b0;
            count_q  <= '0;
        end else begin
            wptr     <= wptr_nxt;
            rptr     <= rptr_nxt;
            vld_p1   <= vld_p0;
            tready_q <= !full_nxt;
            count_q  <= count_q + CLEN'(s_hs) - CLEN'(m_hs);
        end
    end

    // ---- stage p1: RAM data returns, tlast flag follows it ----------------
    always_ff @(posedge clk) begin
        if (s_hs)   last_mem[widx] <= s_axis_tlast;
        if (vld_p0) last_p1        <= last_mem[ridx];
    end

    // ---- stage p2: output buffer drives the downstream port ---------------
    axis_fifo_obuf #(
        .DLEN (DLEN)
    ) u_obuf (
        .clk       (clk),
        .rstn      (rstn),
        .push      (vld_p1),
        .push_data (i_rdata),
        .push_last (last_p1),
        .pop       (m_hs),
        .head_data (m_axis_tdata),
        .head_last (m_axis_tlast),
        .occ       (occ)
    );

    assign m_axis_tvalid = (occ != 2'd0);
    assign s_axis_tready = tready_q;

    assign o_wen   = s_hs;
    assign o_waddr = ALEN'(word2addr(32'(widx), WLEN));
    assign o_wdata = s_axis_tdata;
    assign o_ren   = vld_p0;
    assign o_raddr = ALEN'(word2addr(32'(ridx), WLEN));

    assign o_count = count_q;
    assign o_full  = full;
    assign o_empty = (count_q == '0);

endmodule

// File: tb/tb_axis_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_axis_fifo_ctrl
// Directed bench for axis_fifo_ctrl with DEPTH=4 and WLEN=4. A behavioural
// RAM with one clock of read latency sits on the RAM ports.
// -----------------------------------------------------------------------------
module tb_axis_fifo_ctrl;

    localparam int BLEN  = 8;
    localparam int WLEN  = 4;
    localparam int DLEN  = 32;
    localparam int DEPTH = 4;
    localparam int ALEN  = 4;
    localparam int CLEN  = 3;

    logic            clk = 1'b0;
    logic            rstn;
    logic            s_axis_tvalid;
    logic            s_axis_tready;
    logic [DLEN-1:0] s_axis_tdata;
    logic            s_axis_tlast;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic [DLEN-1:0] m_axis_tdata;
    logic            m_axis_tlast;
    logic            o_wen;
    logic [ALEN-1:0] o_waddr;
    logic [DLEN-1:0] o_wdata;
    logic            o_ren;
    logic [ALEN-1:0] o_raddr;
    logic [DLEN-1:0] i_rdata;
    logic [CLEN-1:0] o_count;
    logic            o_full;
    logic            o_empty;

    always #5 clk = ~clk;

    axis_fifo_ctrl #(
        .BLEN  (BLEN),
        .WLEN  (WLEN),
        .DLEN  (DLEN),
        .DEPTH (DEPTH),
        .ALEN  (ALEN),
        .CLEN  (CLEN)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .o_wen         (o_wen),
        .o_waddr       (o_waddr),
        .o_wdata       (o_wdata),
        .o_ren         (o_ren),
        .o_raddr       (o_raddr),
        .i_rdata       (i_rdata),
        .o_count       (o_count),
        .o_full        (o_full),
        .o_empty       (o_empty)
    );

    // RAM model: the write commits at the edge, and the read data is
    // registered, so it is valid the cycle after o_ren.
    logic [DLEN-1:0] ram [DEPTH];
    always_ff @(posedge clk) begin
        if (o_wen) ram[o_waddr[ALEN-1:2]] <= o_wdata;
        if (o_ren) i_rdata <= ram[o_raddr[ALEN-1:2]];
    end

    // Count the writes and reads since reset. These counts give the word
    // address that each RAM access is expected to use.
    int wr_total = 0;
    int rd_total = 0;
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_total <= 0;
            rd_total <= 0;
        end else begin
            if (s_axis_tvalid && s_axis_tready) wr_total <= wr_total + 1;
            if (o_ren) rd_total <= rd_total + 1;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] beat_data(input int i);
        return (32'(i) * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    function automatic logic beat_last(input int i);
        return (i % 5) == 4;
    endfunction

    function automatic logic [63:0] word_addr(input int n);
        return 64'((n % DEPTH) * WLEN);
    endfunction

    task automatic do_reset();
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Streams n beats through the FIFO. The upstream source holds an offered
    // beat until it is accepted. When rnd is set, valid and ready are
    // randomised. Every handshake is scored against the sent sequence.
    task automatic run_traffic(input string tag, input int n, input bit rnd,
                               input int max_cyc);
        int   sent = 0;
        int   recvd = 0;
        int   cyc = 0;
        int   first_cyc = -1;
        int   last_cyc = -1;
        bit   pending = 1'b0;
        bit   stall = 1'b0;
        logic [32:0] held = '0;
        while (recvd < n && cyc < max_cyc) begin
            if (!pending) begin
                if (sent < n && (!rnd || $urandom_range(0, 3) != 0)) begin
                    s_axis_tvalid = 1'b1;
                    s_axis_tdata  = beat_data(sent);
                    s_axis_tlast  = beat_last(sent);
                end else begin
                    s_axis_tvalid = 1'b0;
                end
            end
            m_axis_tready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            #1;
            if (stall)
                check_val({tag, "_hold"}, 64'({m_axis_tvalid, m_axis_tlast, m_axis_tdata}),
                          64'({1'b1, held}));
            if (o_wen)
                check_val({tag, "_waddr"}, 64'(o_waddr), word_addr(wr_total));
            if (o_ren)
                check_val({tag, "_raddr"}, 64'(o_raddr), word_addr(rd_total));
            if (m_axis_tvalid && m_axis_tready) begin
                check_val({tag, "_beat"}, 64'({m_axis_tlast, m_axis_tdata}),
                          64'({beat_last(recvd), beat_data(recvd)}));
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                recvd++;
            end
            stall = m_axis_tvalid && !m_axis_tready;
            held  = {m_axis_tlast, m_axis_tdata};
            if (s_axis_tvalid && s_axis_tready) begin
                sent++;
                pending = 1'b0;
            end else begin
                pending = s_axis_tvalid;
            end
            cyc++;
            @(posedge clk);
            #1;
        end
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        #1;
        check_val({tag, "_count"}, 64'(recvd), 64'(n));
        if (!rnd)
            check_val({tag, "_rate"}, 64'(last_cyc - first_cyc), 64'(n - 1));
        check_val({tag, "_empty"}, 64'(o_empty), 64'd1);
    endtask

    logic [63:0] fill_addr [6];
    int acc;
    int got;

    initial begin
        fill_addr = '{64'h0, 64'h4, 64'h8, 64'hC, 64'h0, 64'h4};
        rstn = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_tready", 64'(s_axis_tready), 64'd0);
        check_val("rst_mvalid", 64'(m_axis_tvalid), 64'd0);
        check_val("rst_wen",    64'(o_wen),         64'd0);
        check_val("rst_ren",    64'(o_ren),         64'd0);
        check_val("rst_count",  64'(o_count),       64'd0);
        check_val("rst_empty",  64'(o_empty),       64'd1);
        check_val("rst_full",   64'(o_full),        64'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check_val("rel_tready", 64'(s_axis_tready), 64'd1);
        check_val("rel_count",  64'(o_count),       64'd0);

        // Single beat: the write is at E0, the read issues the next cycle,
        // and the output appears after E2
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'hDEAD_BEEF;
        s_axis_tlast  = 1'b1;
        #1;
        check_val("one_wen",   64'(o_wen),   64'd1);
        check_val("one_waddr", 64'(o_waddr), 64'h0);
        check_val("one_wdata", 64'(o_wdata), 64'hDEAD_BEEF);
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        #1;
        check_val("one_ren",    64'(o_ren),         64'd1);
        check_val("one_raddr",  64'(o_raddr),       64'h0);
        check_val("one_mv_e0",  64'(m_axis_tvalid), 64'd0);
        @(posedge clk);
        #2;
        check_val("one_mv_e1",  64'(m_axis_tvalid), 64'd0);
        check_val("one_ren_e1", 64'(o_ren),         64'd0);
        @(posedge clk);
        #2;
        check_val("one_mv_e2",  64'(m_axis_tvalid), 64'd1);
        check_val("one_mdata",  64'(m_axis_tdata),  64'hDEAD_BEEF);
        check_val("one_mlast",  64'(m_axis_tlast),  64'd1);
        check_val("one_count",  64'(o_count),       64'd1);
        m_axis_tready = 1'b1;
        @(posedge clk);
        #1;
        m_axis_tready = 1'b0;
        #1;
        check_val("one_mv_pop", 64'(m_axis_tvalid), 64'd0);
        check_val("one_empty",  64'(o_empty),       64'd1);

        // Fill with the sink stalled. Four words fit in the RAM and two in
        // the output buffer.
        do_reset();
        acc = 0;
        for (int c = 0; c < 12; c++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 32'(acc + 1);
            s_axis_tlast  = (acc == 5);
            #1;
            if (s_axis_tready) begin
                if (acc < 6) check_val("fill_waddr", 64'(o_waddr), fill_addr[acc]);
                acc++;
            end
            @(posedge clk);
            #1;
        end
        check_val("fill_accepted", 64'(acc),           64'd6);
        check_val("fill_full",     64'(o_full),        64'd1);
        check_val("fill_tready",   64'(s_axis_tready), 64'd0);
        check_val("fill_wen",      64'(o_wen),         64'd0);
        check_val("fill_count",    64'(o_count),       64'd6);
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 6; c++) begin
            #1;
            if (m_axis_tvalid) begin
                check_val("drain_beat", 64'({m_axis_tlast, m_axis_tdata}),
                          64'({got == 5, 32'(got + 1)}));
                got++;
            end
            @(posedge clk);
            #1;
        end
        m_axis_tready = 1'b0;
        #1;
        check_val("drain_count", 64'(got),     64'd6);
        check_val("drain_empty", 64'(o_empty), 64'd1);

        // Full-rate streaming, then random back-pressure
        run_traffic("stream", 100, 1'b0, 200);
        run_traffic("rand", 1000, 1'b1, 8000);

        // Reset with five beats held, in the middle of a packet
        acc = 0;
        for (int c = 0; c < 10 && acc < 5; c++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 32'h5000 + 32'(acc);
            s_axis_tlast  = 1'b0;
            #1;
            if (s_axis_tready) acc++;
            @(posedge clk);
            #1;
        end
        s_axis_tvalid = 1'b0;
        #1;
        check_val("mid_count", 64'(o_count), 64'd5);
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check_val("mid_rst_count",  64'(o_count),       64'd0);
        check_val("mid_rst_mvalid", 64'(m_axis_tvalid), 64'd0);
        check_val("mid_rst_empty",  64'(o_empty),       64'd1);
        check_val("mid_rst_tready", 64'(s_axis_tready), 64'd1);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'h1234_5678;
        s_axis_tlast  = 1'b1;
        #1;
        check_val("mid_wen",   64'(o_wen),   64'd1);
        check_val("mid_waddr", 64'(o_waddr), 64'h0);
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        got = 0;
        for (int c = 0; c < 10 && got == 0; c++) begin
            @(posedge clk);
            #1;
            if (m_axis_tvalid) begin
                check_val("mid_beat", 64'({m_axis_tlast, m_axis_tdata}),
                          64'({1'b1, 32'h1234_5678}));
                got = 1;
            end
        end
        @(posedge clk);
        #1;
        m_axis_tready = 1'b0;
        check_val("mid_rx",    64'(got),     64'd1);
        check_val("mid_empty", 64'(o_empty), 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
